// File: rtl/stoch_queue_engine_if.sv
// Command/response handshake bundle for the stochastic-queue engine.
// The master issues $q_* commands; the slave serves them one at a time.
interface stoch_queue_engine_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_q_id;
   logic [31:0] cmd_q_type;
   logic [31:0] cmd_max_len;
   logic [31:0] cmd_item;
   logic [31:0] cmd_weight;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_status;
   logic [31:0] rsp_item;
   logic [31:0] rsp_weight;
   logic [31:0] rsp_value;

   modport master (
      output cmd_valid, cmd_op, cmd_q_id, cmd_q_type,
      output cmd_max_len, cmd_item, cmd_weight, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_status,
      input  rsp_item, rsp_weight, rsp_value
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_q_id, cmd_q_type,
      input  cmd_max_len, cmd_item, cmd_weight, rsp_ready,
      output cmd_ready, rsp_valid, rsp_status,
      output rsp_item, rsp_weight, rsp_value
   );
endinterface

// File: rtl/stoch_queue_engine.sv
// Single FIFO/LIFO item/weight queue answering $q_* commands
// with the standard status codes, one command in flight.
module stoch_queue_engine #(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input logic clk,
   input logic rst_n,
   stoch_queue_engine_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] qid_q, qid_d;
   logic [31:0] typ_q, typ_d;
   logic [31:0] mlen_q, mlen_d;
   logic [31:0] item_q, item_d;
   logic [31:0] wgt_q, wgt_d;

   logic             init_q, init_d;
   logic [31:0]      id_q, id_d;
   logic             lifo_q, lifo_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] peak_q, peak_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;

   logic [31:0] st_q, st_d;
   logic [31:0] ritem_q, ritem_d;
   logic [31:0] rwgt_q, rwgt_d;
   logic [31:0] rval_q, rval_d;

   logic [63:0]      mem [DEPTH];
   logic             wr_en;
   logic [PW-1:0]    rd_ptr;
   logic [63:0]      rd_data;
   logic             hit;
   logic [CNT_W-1:0] cnt_inc;

   assign bus.cmd_ready  = (state_q == S_IDLE);
   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.rsp_status = st_q;
   assign bus.rsp_item   = ritem_q;
   assign bus.rsp_weight = rwgt_q;
   assign bus.rsp_value  = rval_q;

   // LIFO pops from the slot just below the tail
   assign rd_ptr  = lifo_q ? tail_q - PW'(1) : head_q;
   assign rd_data = mem[rd_ptr];
   assign hit     = init_q && (qid_q == id_q);
   assign cnt_inc = count_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      qid_d   = qid_q;
      typ_d   = typ_q;
      mlen_d  = mlen_q;
      item_d  = item_q;
      wgt_d   = wgt_q;
      init_d  = init_q;
      id_d    = id_q;
      lifo_d  = lifo_q;
      max_d   = max_q;
      count_d = count_q;
      peak_d  = peak_q;
      head_d  = head_q;
      tail_d  = tail_q;
      st_d    = st_q;
      ritem_d = ritem_q;
      rwgt_d  = rwgt_q;
      rval_d  = rval_q;
      wr_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               qid_d   = bus.cmd_q_id;
               typ_d   = bus.cmd_q_type;
               mlen_d  = bus.cmd_max_len;
               item_d  = bus.cmd_item;
               wgt_d   = bus.cmd_weight;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_RESP;
            st_d    = 32'd1;
            ritem_d = '0;
            rwgt_d  = '0;
            rval_d  = '0;
            if (op_q == 3'd0) begin
               if (init_q)
                  st_d = 32'd7;
               else if (typ_q != 32'd1 && typ_q != 32'd2)
                  st_d = 32'd5;
               else if ($signed(mlen_q) <= 0)
                  st_d = 32'd6;
               else if (mlen_q > 32'(DEPTH))
                  st_d = 32'd8;
               else begin
                  init_d  = 1'b1;
                  id_d    = qid_q;
                  lifo_d  = (typ_q == 32'd2);
                  max_d   = CNT_W'(mlen_q);
                  count_d = '0;
                  peak_d  = '0;
               end
            end else if (op_q > 3'd4) begin
               st_d = 32'd5;
            end else if (!hit) begin
               st_d = 32'd3;
            end else begin
               case (op_q)
                  3'd1: begin
                     if (count_q == max_q)
                        st_d = 32'd2;
                     else begin
                        wr_en   = 1'b1;
                        tail_d  = tail_q + PW'(1);
                        count_d = cnt_inc;
                        if (cnt_inc > peak_q)
                           peak_d = cnt_inc;
                     end
                  end
                  3'd2: begin
                     if (count_q == '0)
                        st_d = 32'd4;
                     else begin
                        ritem_d = rd_data[63:32];
                        rwgt_d  = rd_data[31:0];
                        count_d = count_q - CNT_W'(1);
                        if (lifo_q)
                           tail_d = rd_ptr;
                        else
                           head_d = head_q + PW'(1);
                     end
                  end
                  3'd3: begin
                     if (item_q == 32'd1)
                        rval_d = 32'(count_q);
                     else if (item_q == 32'd3)
                        rval_d = 32'(peak_q);
                     else
                        st_d = 32'd5;
                  end
                  default: rval_d = {31'd0, count_q == max_q};
               endcase
            end
         end
         S_RESP: begin
            if (bus.rsp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         qid_q   <= '0;
         typ_q   <= '0;
         mlen_q  <= '0;
         item_q  <= '0;
         wgt_q   <= '0;
         init_q  <= 1'b0;
         id_q    <= '0;
         lifo_q  <= 1'b0;
         max_q   <= '0;
         count_q <= '0;
         peak_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         st_q    <= '0;
         ritem_q <= '0;
         rwgt_q  <= '0;
         rval_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         qid_q   <= qid_d;
         typ_q   <= typ_d;
         mlen_q  <= mlen_d;
         item_q  <= item_d;
         wgt_q   <= wgt_d;
         init_q  <= init_d;
         id_q    <= id_d;
         lifo_q  <= lifo_d;
         max_q   <= max_d;
         count_q <= count_d;
         peak_q  <= peak_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         st_q    <= st_d;
         ritem_q <= ritem_d;
         rwgt_q  <= rwgt_d;
         rval_q  <= rval_d;
      end
   end

   // Storage needs no reset; its contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[tail_q] <= {item_q, wgt_q};
   end
endmodule

// File: tb/tb_stoch_queue_engine.sv
// Directed plus randomized checks of stoch_queue_engine against
// a queue-based model of the $q_* semantics.
module tb_stoch_queue_engine;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stoch_queue_engine_if bus();

   stoch_queue_engine #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   bit          m_init;
   logic [31:0] m_id;
   bit          m_lifo;
   int          m_max;
   int          m_peak;
   logic [63:0] mq[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [2:0] op, input logic [31:0] id,
                        input logic [31:0] typ, input logic [31:0] mx,
                        input logic [31:0] it, input logic [31:0] wt,
                        output logic [31:0] st, output logic [31:0] ri,
                        output logic [31:0] rw, output logic [31:0] rv);
      logic [63:0] e;
      st = 1; ri = 0; rw = 0; rv = 0;
      if (op == 0) begin
         if (m_init) st = 7;
         else if (typ != 1 && typ != 2) st = 5;
         else if ($signed(mx) <= 0) st = 6;
         else if (mx > DEPTH) st = 8;
         else begin
            m_init = 1; m_id = id; m_lifo = (typ == 2);
            m_max = int'(mx); m_peak = 0; mq.delete();
         end
      end else if (op > 4) st = 5;
      else if (!m_init || id != m_id) st = 3;
      else if (op == 1) begin
         if (mq.size() == m_max) st = 2;
         else begin
            mq.push_back({it, wt});
            if (mq.size() > m_peak) m_peak = mq.size();
         end
      end else if (op == 2) begin
         if (mq.size() == 0) st = 4;
         else begin
            e = m_lifo ? mq.pop_back() : mq.pop_front();
            ri = e[63:32]; rw = e[31:0];
         end
      end else if (op == 3) begin
         if (it == 1) rv = mq.size();
         else if (it == 3) rv = m_peak;
         else st = 5;
      end else rv = (mq.size() == m_max) ? 1 : 0;
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [31:0] id,
                         input logic [31:0] typ, input logic [31:0] mx,
                         input logic [31:0] it, input logic [31:0] wt,
                         input int stall);
      logic [31:0] st, ri, rw, rv;
      int n;
      model(op, id, typ, mx, it, wt, st, ri, rw, rv);
      @(negedge clk);
      bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_q_id = id;
      bus.cmd_q_type = typ; bus.cmd_max_len = mx;
      bus.cmd_item = it; bus.cmd_weight = wt;
      bus.rsp_ready = (stall == 0);
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge clk); n++;
      end
      chk("accept_timeout", 32'(n < 20), 1);
      @(posedge clk); #1;
      bus.cmd_valid = 0;
      bus.cmd_op = 3'($urandom); bus.cmd_q_id = $urandom;
      bus.cmd_item = $urandom; bus.cmd_weight = $urandom;
      bus.cmd_max_len = $urandom; bus.cmd_q_type = $urandom;
      chk("exec_no_valid", 32'(bus.rsp_valid), 0);
      chk("exec_not_ready", 32'(bus.cmd_ready), 0);
      @(posedge clk); #1;
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("status", bus.rsp_status, st);
      chk("item", bus.rsp_item, ri);
      chk("weight", bus.rsp_weight, rw);
      chk("value", bus.rsp_value, rv);
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(bus.rsp_valid), 1);
         chk("stall_ready", 32'(bus.cmd_ready), 0);
         chk("stall_status", bus.rsp_status, st);
         chk("stall_item", bus.rsp_item, ri);
         chk("stall_value", bus.rsp_value, rv);
      end
      bus.rsp_ready = 1;
      @(posedge clk); #1;
      chk("rsp_done", 32'(bus.rsp_valid), 0);
      chk("back_idle", 32'(bus.cmd_ready), 1);
   endtask

   task automatic do_reset();
      rst_n = 0;
      m_init = 0; m_peak = 0; mq.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_ready", 32'(bus.cmd_ready), 1);
      chk("rst_status", bus.rsp_status, 0);
      chk("rst_value", bus.rsp_value, 0);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_q_id = 0;
      bus.cmd_q_type = 0; bus.cmd_max_len = 0;
      bus.cmd_item = 0; bus.cmd_weight = 0; bus.rsp_ready = 1;
      do_reset();

      do_cmd(3'd1, 7, 0, 0, 1, 1, 0);
      do_cmd(3'd0, 7, 3, 4, 0, 0, 0);
      do_cmd(3'd0, 7, 1, 0, 0, 0, 0);
      do_cmd(3'd0, 7, 1, 32'hffff_fffe, 0, 0, 0);
      do_cmd(3'd0, 7, 1, 17, 0, 0, 0);
      do_cmd(3'd0, 7, 1, 4, 0, 0, 0);
      for (int i = 1; i <= 3; i++)
         do_cmd(3'd1, 7, 0, 0, 10 * i, 100 * i, 0);
      for (int i = 0; i < 4; i++)
         do_cmd(3'd2, 7, 0, 0, 0, 0, 0);
      do_cmd(3'd0, 7, 2, 2, 0, 0, 0);

      do_reset();
      do_cmd(3'd0, 7, 2, 2, 0, 0, 0);
      do_cmd(3'd1, 7, 0, 0, 1, 11, 0);
      do_cmd(3'd1, 7, 0, 0, 2, 22, 0);
      do_cmd(3'd4, 7, 0, 0, 0, 0, 0);
      do_cmd(3'd1, 7, 0, 0, 3, 33, 0);
      do_cmd(3'd2, 7, 0, 0, 0, 0, 0);
      do_cmd(3'd4, 7, 0, 0, 0, 0, 0);

      do_reset();
      do_cmd(3'd0, 7, 1, 16, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         do_cmd(3'd1, 7, 0, 0, 1000 + i, $urandom, 0);
         do_cmd(3'd2, 7, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 16; i++)
         do_cmd(3'd1, 7, 0, 0, 2000 + i, $urandom, 0);
      do_cmd(3'd3, 7, 0, 0, 1, 0, 0);
      do_cmd(3'd3, 7, 0, 0, 3, 0, 0);
      do_cmd(3'd3, 7, 0, 0, 2, 0, 0);
      do_cmd(3'd4, 7, 0, 0, 0, 0, 0);
      do_cmd(3'd1, 7, 0, 0, 9, 9, 0);
      do_cmd(3'd2, 7, 0, 0, 0, 0, 5);
      do_cmd(3'd1, 8, 0, 0, 5, 5, 0);
      do_cmd(3'd3, 7, 0, 0, 1, 0, 0);
      do_cmd(3'd6, 7, 0, 0, 0, 0, 2);

      for (int i = 0; i < 80; i++) begin
         logic [2:0] op;
         logic [31:0] id, it;
         op = 3'($urandom_range(1, 4));
         id = ($urandom_range(0, 9) == 0) ? 32'd8 : 32'd7;
         it = (op == 3) ? 32'($urandom_range(0, 4)) : $urandom;
         do_cmd(op, id, 0, 0, it, $urandom, $urandom_range(0, 2));
      end

      @(negedge clk);
      bus.cmd_valid = 1; bus.cmd_op = 3'd4; bus.cmd_q_id = 7;
      bus.rsp_ready = 0;
      @(posedge clk); #1;
      bus.cmd_valid = 0;
      @(posedge clk); #1;
      chk("mid_valid", 32'(bus.rsp_valid), 1);
      rst_n = 0;
      m_init = 0; m_peak = 0; mq.delete();
      #1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
      chk("mid_rst_ready", 32'(bus.cmd_ready), 1);
      @(negedge clk);
      rst_n = 1;
      bus.rsp_ready = 1;
      do_cmd(3'd1, 7, 0, 0, 4, 4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stoch_queue_engine.md
# stoch_queue_engine

Synthesizable responder for the stochastic-queue operations (initialize, add, remove, examine, full-query) that SystemTasks test modules drive as `$q_*` calls. It holds one FIFO or LIFO queue of item/weight pairs in on-chip storage and serves one command at a time over a valid/ready request/response pair. It returns the standard `$q_*` status codes, so a bench can compare its results against the simulator's built-in tasks.

## Interface
- DEPTH, 16: physical entry capacity, power of two, 2..256
- CNT_W, $clog2(DEPTH)+1: width of the internal count and max-length registers
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine accepts command this cycle
- cmd_op  in  3  0 INIT, 1 ADD, 2 REMOVE, 3 EXAM, 4 FULL; 5-7 reserved
- cmd_q_id  in  32  queue handle
- cmd_q_type  in  32  INIT: 1 = FIFO, 2 = LIFO
- cmd_max_len  in  32  INIT: logical length limit
- cmd_item  in  32  ADD: job id; EXAM: exam code
- cmd_weight  in  32  ADD: inform id
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_status  out  32  `$q_*` status code
- rsp_item  out  32  REMOVE: job id
- rsp_weight  out  32  REMOVE: inform id
- rsp_value  out  32  EXAM result, or FULL flag

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - EXEC: one cycle; performs the operation and registers the response fields.
  - RESP: rsp_valid = 1; held until rsp_ready, then back to IDLE.
- Only one command is in flight. cmd_ready is 0 in EXEC and RESP.
- Status codes:
  - 1: OK
  - 2: full, ADD rejected
  - 3: undefined q_id
  - 4: empty, REMOVE rejected
  - 5: unsupported q_type, or reserved op
  - 6: max_len ≤ 0 (signed compare)
  - 7: INIT while already initialized
  - 8: max_len > DEPTH
- INIT:
  - Checked in order: 7, 5, 6, 8.
  - On success, latch q_id, q_type and max_len. Set count = 0, peak = 0, initialized = 1.
- Any other op, when not initialized or when cmd_q_id ≠ latched id: status 3, no state change.
- ADD:
  - count == max_len: status 2.
  - Otherwise write {item, weight} at tail, tail++, count++, peak = max(peak, count), status 1.
- REMOVE:
  - count == 0: status 4, rsp_item = rsp_weight = 0.
  - FIFO: read at head, head++.
  - LIFO: tail--, read at new tail.
  - count--, status 1.
- EXAM (status 1):
  - code 1: rsp_value = count.
  - code 3: rsp_value = peak.
  - Any other code: rsp_value = 0, status 5.
- FULL: rsp_value = (count == max_len), status 1.
- Reserved op: status 5, no state change.
- Response field rules:
  - Fields not defined for the op are driven 0.
  - rsp_value is zero-extended from CNT_W bits.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- The queue is never deallocated. Only reset clears initialized.

## Timing
- Reset, asynchronous:
  - State = IDLE, cmd_ready = 1, rsp_valid = 0.
  - All rsp_* = 0, count = peak = head = tail = 0, initialized = 0.
- Reset asserted mid-operation aborts the command with no response. Storage contents are don't-care.
- Latency:
  - Command accepted at edge N (cmd_valid & cmd_ready).
  - rsp_valid rises after edge N+1.
  - Earliest response transfer is at edge N+2.
- Throughput: one command per 3 cycles with rsp_ready held at 1.
- Response hold: rsp_* stay stable while rsp_valid & !rsp_ready, for any stall length.
- Queue state (count, pointers, peak) updates at the EXEC edge, before the response is visible.
- cmd_* inputs are sampled only at the accept edge and may change afterward.

## Test plan
- Bad init: INIT id 7, type 3, max 4 -> status 5. INIT id 7, type 1, max 0 -> status 6. INIT id 7, type 1, max 17 (DEPTH 16) -> status 8. A second successful INIT -> status 7.
- FIFO order: INIT id 7, FIFO, max 4. ADD (10,100), (20,200), (30,300) -> status 1 each. REMOVE ×3 -> (10,100), (20,200), (30,300). REMOVE -> status 4.
- LIFO and full: INIT LIFO, max 2. ADD 1, 2 -> FULL returns value 1. ADD 3 -> status 2. REMOVE -> item 2. FULL returns value 0.
- Wrap and stats: FIFO with max 16. Run 40 interleaved ADD/REMOVE pairs, then fill to 16. Data order is preserved across pointer wrap. EXAM code 1 -> 16, code 3 -> 16, code 2 -> status 5.
- Handshake and id: hold rsp_ready = 0 for 5 cycles -> rsp_* stable and cmd_ready = 0 throughout. Send ADD with id 8 after INIT id 7 -> status 3, and EXAM code 1 afterward is unchanged.
- Reset mid-op: assert rst_n low while in RESP -> rsp_valid = 0 immediately. After release, ADD -> status 3.
